// File: rtl/morse_pkg.sv
// Shared constants for the Morse sequence assembler.
//   SYM_*  : 3-bit symbol codes arriving from the signal classifier
//   SLOT_* : 2-bit slot encodings packed MSB-first into the encoded word
//   enc_w  : encoded word width for a given maximum symbol count
package morse_pkg;

  localparam logic [2:0] SYM_DOT   = 3'b000;
  localparam logic [2:0] SYM_DASH  = 3'b001;
  localparam logic [2:0] SYM_SPACE = 3'b010;
  localparam logic [2:0] SYM_END   = 3'b011;

  localparam logic [1:0] SLOT_DOT  = 2'b00;
  localparam logic [1:0] SLOT_DASH = 2'b01;
  localparam logic [1:0] SLOT_PAD  = 2'b11;

  function automatic int unsigned enc_w(input int unsigned max_symbols);
    return 2 * max_symbols;
  endfunction

endpackage

// File: rtl/morse_word_fifo.sv
// Generic synchronous FIFO with asynchronous active-high reset and a
// registered head output.
//   clk_i, rst_i : clock, async reset
//   push_i/din_i : write request and data (ignored when full)
//   pop_i        : read request (ignored when empty)
//   dout_o       : head entry; holds its last value once the FIFO drains
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module morse_word_fifo #(
  parameter int unsigned        WIDTH     = 8,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = head_q;

  always_comb begin
    wr_d   = push_ok ? wr_q + (AW+1)'(1) : wr_q;
    rd_d   = pop_ok  ? rd_q + (AW+1)'(1) : rd_q;
    head_d = head_q;
    // Head register tracks the entry at the post-edge read pointer; when
    // the pushed word lands exactly there it bypasses the memory.
    if (wr_d != rd_d) begin
      if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = din_i;
      else                                           head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= RESET_VAL;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/morse_seq_assembler.sv
// Packs dot/dash symbols into an MSB-first, 11-padded encoded word, closes
// the word on space or end-of-sequence, and queues closed words in an
// output FIFO.
//   Clock, Reset     : clock, async active-high reset
//   Signals/SigValid : symbol code and qualifier; transfer when InReady
//   InReady          : FIFO not full
//   Clear            : drop the partial word (FIFO untouched)
//   EncSeq/SymCount/Space_EndSeqbar/Overflow : head-of-FIFO word fields
//   OutValid/OutReady: output handshake
//   SentFlag         : toggles on each word pushed
module morse_seq_assembler
  import morse_pkg::*;
#(
  parameter  int unsigned MAX_SYMBOLS = 5,
  parameter  int unsigned DEPTH       = 4,
  localparam int unsigned ENC_W       = enc_w(MAX_SYMBOLS),
  localparam int unsigned CNT_W       = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       Signals,
  input  logic             SigValid,
  output logic             InReady,
  input  logic             Clear,
  output logic [ENC_W-1:0] EncSeq,
  output logic [CNT_W-1:0] SymCount,
  output logic             Space_EndSeqbar,
  output logic             Overflow,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             SentFlag
);

  localparam int unsigned WORD_W = ENC_W + CNT_W + 2;
  localparam logic [WORD_W-1:0] WORD_RST = {1'b0, 1'b1, {CNT_W{1'b0}}, {ENC_W{1'b1}}};

  logic [ENC_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic              sent_q;
  logic              fifo_full, fifo_empty;
  logic              accept, is_term, is_sym, push;
  logic [WORD_W-1:0] word, head;

  assign InReady  = !fifo_full;
  assign OutValid = !fifo_empty;
  assign SentFlag = sent_q;

  // Clear discards any same-cycle input, including a terminator.
  assign accept  = SigValid && !fifo_full && !Clear;
  assign is_term = (Signals == SYM_SPACE) || (Signals == SYM_END);
  assign is_sym  = (Signals == SYM_DOT) || (Signals == SYM_DASH);
  assign push    = accept && is_term;
  assign word    = {ovf_q, (Signals == SYM_SPACE), idx_q, buf_q};

  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    if (Clear || push) begin
      buf_d = '1;
      idx_d = '0;
      ovf_d = 1'b0;
    end else if (accept && is_sym) begin
      if (idx_q == CNT_W'(MAX_SYMBOLS)) begin
        ovf_d = 1'b1;
      end else begin
        idx_d = idx_q + CNT_W'(1);
        for (int unsigned k = 0; k < MAX_SYMBOLS; k++) begin
          if (idx_q == CNT_W'(k))
            buf_d[ENC_W-1-2*k -: 2] = (Signals == SYM_DASH) ? SLOT_DASH : SLOT_DOT;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      buf_q  <= '1;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
      sent_q <= 1'b1;
    end else begin
      buf_q  <= buf_d;
      idx_q  <= idx_d;
      ovf_q  <= ovf_d;
      if (push) sent_q <= ~sent_q;
    end
  end

  morse_word_fifo #(
    .WIDTH     (WORD_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (WORD_RST)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (push),
    .din_i   (word),
    .pop_i   (OutReady),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {Overflow, Space_EndSeqbar, SymCount, EncSeq} = head;

endmodule

// File: tb/tb_morse_seq_assembler.sv
module tb_morse_seq_assembler;

  localparam int MAXS = 5;
  localparam int DEP  = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] Signals = 3'b000;
  logic       SigValid = 1'b0;
  logic       Clear = 1'b0;
  logic       OutReady = 1'b0;
  logic       InReady;
  logic [9:0] EncSeq;
  logic [2:0] SymCount;
  logic       Space_EndSeqbar;
  logic       Overflow;
  logic       OutValid;
  logic       SentFlag;

  morse_seq_assembler #(.MAX_SYMBOLS(MAXS), .DEPTH(DEP)) dut (
    .Clock(Clock), .Reset(Reset), .Signals(Signals), .SigValid(SigValid),
    .InReady(InReady), .Clear(Clear), .EncSeq(EncSeq), .SymCount(SymCount),
    .Space_EndSeqbar(Space_EndSeqbar), .Overflow(Overflow),
    .OutValid(OutValid), .OutReady(OutReady), .SentFlag(SentFlag)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [9:0] enc;
    int         cnt;
    bit         sp;
    bit         ovf;
  } word_t;

  word_t m_q[$];
  int    m_sym[$];   // 0 = dot, 1 = dash
  bit    m_ovf;
  bit    m_sent;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sym.delete();
    m_ovf  = 1'b0;
    m_sent = 1'b1;
  endtask

  function automatic word_t make_word(input bit sp);
    word_t w;
    w.enc = '0;
    for (int k = 0; k < MAXS; k++)
      w.enc = {w.enc[7:0], (k < m_sym.size()) ? (m_sym[k] == 1 ? 2'b01 : 2'b00) : 2'b11};
    w.cnt = m_sym.size();
    w.sp  = sp;
    w.ovf = m_ovf;
    return w;
  endfunction

  // One clock edge of the intended behaviour, given inputs held over it.
  task automatic model_update(input logic [2:0] s, input logic v, input logic c, input logic r);
    bit    ready, pop;
    word_t w;
    ready = (m_q.size() < DEP);
    pop   = r && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    if (c) begin
      m_sym.delete();
      m_ovf = 1'b0;
    end else if (v && ready) begin
      if (s == 3'd0 || s == 3'd1) begin
        if (m_sym.size() < MAXS) m_sym.push_back(int'(s));
        else m_ovf = 1'b1;
      end else if (s == 3'd2 || s == 3'd3) begin
        w = make_word(s == 3'd2);
        m_q.push_back(w);
        m_sym.delete();
        m_ovf  = 1'b0;
        m_sent = ~m_sent;
      end
    end
  endtask

  task automatic compare();
    chk("InReady", InReady, (m_q.size() < DEP));
    chk("OutValid", OutValid, (m_q.size() != 0));
    chk("SentFlag", SentFlag, m_sent);
    if (m_q.size() != 0) begin
      chk("EncSeq", EncSeq, m_q[0].enc);
      chk("SymCount", SymCount, m_q[0].cnt);
      chk("Space_EndSeqbar", Space_EndSeqbar, m_q[0].sp);
      chk("Overflow", Overflow, m_q[0].ovf);
    end
  endtask

  // Called at a negedge: drive, update model, cross the posedge, check.
  task automatic step(input logic [2:0] s, input logic v, input logic c, input logic r);
    Signals = s; SigValid = v; Clear = c; OutReady = r;
    model_update(s, v, c, r);
    @(posedge Clock);
    @(negedge Clock);
    compare();
  endtask

  // Called at a negedge; reset asserts and releases between clock edges.
  task automatic async_reset();
    SigValid = 1'b0; Clear = 1'b0; OutReady = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("rst_OutValid", OutValid, 1'b0);
    chk("rst_InReady", InReady, 1'b1);
    chk("rst_SentFlag", SentFlag, 1'b1);
    chk("rst_EncSeq", EncSeq, 10'h3FF);
    chk("rst_SymCount", SymCount, 3'd0);
    chk("rst_Space", Space_EndSeqbar, 1'b1);
    chk("rst_Overflow", Overflow, 1'b0);
    model_reset();
    #1 Reset = 1'b0;
    @(negedge Clock);
    compare();
  endtask

  initial begin
    model_reset();
    @(negedge Clock);
    async_reset();

    // dot, dash, space
    step(3'd0, 1, 0, 0);
    step(3'd1, 1, 0, 0);
    step(3'd2, 1, 0, 0);
    chk("w1_EncSeq", EncSeq, 10'b0001111111);
    chk("w1_SymCount", SymCount, 3'd2);
    chk("w1_Space", Space_EndSeqbar, 1'b1);
    chk("w1_Overflow", Overflow, 1'b0);
    chk("w1_SentFlag", SentFlag, 1'b0);
    step(3'd0, 0, 0, 1);

    // six dashes then end
    for (int i = 0; i < 6; i++) step(3'd1, 1, 0, 0);
    step(3'd3, 1, 0, 0);
    chk("w2_EncSeq", EncSeq, 10'b0101010101);
    chk("w2_SymCount", SymCount, 3'd5);
    chk("w2_Overflow", Overflow, 1'b1);
    chk("w2_Space", Space_EndSeqbar, 1'b0);
    step(3'd0, 0, 0, 1);

    // Clear wins over a terminator
    step(3'd0, 1, 0, 0);
    step(3'd1, 1, 0, 0);
    step(3'd2, 1, 1, 0);
    chk("clr_OutValid", OutValid, 1'b0);
    step(3'd0, 1, 0, 0);
    step(3'd3, 1, 0, 0);
    chk("clr_EncSeq", EncSeq, 10'b0011111111);
    chk("clr_SymCount", SymCount, 3'd1);
    step(3'd0, 0, 0, 1);

    // empty word
    step(3'd2, 1, 0, 0);
    chk("gap_EncSeq", EncSeq, 10'b1111111111);
    chk("gap_SymCount", SymCount, 3'd0);
    chk("gap_Space", Space_EndSeqbar, 1'b1);
    step(3'd0, 0, 0, 1);

    // fill the FIFO, stall, release one slot
    for (int i = 0; i < DEP; i++) begin
      step((i % 2 == 0) ? 3'd0 : 3'd1, 1, 0, 0);
      step(3'd2, 1, 0, 0);
    end
    chk("full_InReady", InReady, 1'b0);
    step(3'd0, 1, 0, 0);
    step(3'd0, 1, 0, 0);
    step(3'd3, 1, 0, 1);
    chk("unfull_InReady", InReady, 1'b1);
    step(3'd3, 1, 0, 0);
    for (int i = 0; i < DEP + 1; i++) step(3'd0, 0, 0, 1);
    chk("drain_OutValid", OutValid, 1'b0);

    // async reset mid-word with two words queued
    step(3'd0, 1, 0, 0);
    step(3'd2, 1, 0, 0);
    step(3'd1, 1, 0, 0);
    step(3'd3, 1, 0, 0);
    step(3'd0, 1, 0, 0);
    async_reset();
    step(3'd1, 1, 0, 0);
    step(3'd3, 1, 0, 0);
    chk("post_rst_EncSeq", EncSeq, 10'b0111111111);
    chk("post_rst_SymCount", SymCount, 3'd1);
    step(3'd0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      logic [2:0]  s;
      sel = $urandom_range(0, 9);
      if (sel < 4)       s = 3'd0;
      else if (sel < 7)  s = 3'd1;
      else if (sel == 7) s = 3'd2;
      else if (sel == 8) s = 3'd3;
      else               s = 3'($urandom_range(4, 7));
      if ($urandom_range(0, 399) == 0) async_reset();
      step(s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_seq_assembler.md
Name: morse_seq_assembler

Overview:
- Clocked, parametrised successor to the combinational sequence producer.
- Packs dot/dash symbols into an MSB-first, 11-padded encoded word and closes the word on Space or EndSeq.
- Queues closed words in an output FIFO with a valid/ready handshake, per-word symbol count and overflow tag.
- Sits between the signal classifier (upstream) and the sequence separator/decoder (downstream).

Parameters:
- MAX_SYMBOLS, 5, max symbols per word; ENC_W = 2*MAX_SYMBOLS.
- DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_W, $clog2(MAX_SYMBOLS+1), width of SymCount (derived; do not override).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Signals  in  3  000 dot, 001 dash, 010 space, 011 end-of-sequence; others ignored
- SigValid  in  1  Signals qualifier, one transfer per cycle when SigValid && InReady
- InReady  out  1  = !FifoFull
- Clear  in  1  synchronous discard of the partial word (FIFO untouched)
- EncSeq  out  ENC_W  head-of-FIFO encoded word
- SymCount  out  CNT_W  symbols stored in the head word
- Space_EndSeqbar  out  1  1 = word closed by space, 0 = by end-of-sequence
- Overflow  out  1  head word received more than MAX_SYMBOLS symbols
- OutValid  out  1  FIFO non-empty
- OutReady  in  1  pops when OutValid && OutReady
- SentFlag  out  1  toggles on every word pushed into the FIFO

Behaviour:
- Reset (async): assembly buffer all ones, symbol index 0, overflow flag 0, FIFO empty, OutValid 0, InReady 1, EncSeq all ones, SymCount 0, Space_EndSeqbar 1, Overflow 0, SentFlag 1.
- Assembly: symbol k (k=0 first) is written at bits [ENC_W-1-2k -: 2]. Dot is 00, dash is 01, unused slots are 11.
- Accepted dot/dash with index < MAX_SYMBOLS: write the slot, index+1.
- Accepted dot/dash with index == MAX_SYMBOLS: symbol dropped, sticky overflow flag set, index held.
- Accepted 010/011: push {overflow, Space=(code==010), index, buffer} to the FIFO. Same edge: buffer all ones, index 0, overflow 0, SentFlag toggles.
- Empty word (terminator with index 0) is pushed as all ones with count 0 and marks a word gap.
- Codes 1xx accepted and ignored; no state change.
- Clear high: buffer/index/overflow reset. Any same-cycle input is discarded, and Clear wins over a terminator, so no push occurs. FIFO and SentFlag are unaffected.
- InReady low (FIFO full): all input stalls and the upstream holds Signals. Assembly is not advanced even for dot/dash.
- FIFO: registered outputs show the head entry. Latency: terminator accepted at edge N gives OutValid at N+1 when the FIFO was empty.
- Simultaneous push and pop when non-empty: both occur, occupancy unchanged.
- Pop on the last entry with no push: OutValid 0 next cycle. Output fields hold the last popped value (not required to be cleared).
- Full: count == DEPTH. Pointers carry one extra wrap bit; full/empty are decided by pointer compare, wrap-around at DEPTH.
- Reset mid-word or with a non-empty FIFO: everything is discarded immediately (asynchronous).

Decomposition:
- Package morse_pkg:
  - SYM_DOT=3'b000, SYM_DASH=3'b001, SYM_SPACE=3'b010, SYM_END=3'b011
  - SLOT_DOT=2'b00, SLOT_DASH=2'b01, SLOT_PAD=2'b11
  - helper function enc_w(MAX_SYMBOLS)
- Sub-module morse_word_fifo:
  - generic width/depth synchronous FIFO with async reset, push/pop/full/empty.
  - Instantiated with width ENC_W+CNT_W+2.
- Top level holds the assembly FSM/datapath only.

Test Plan:
- Reset, then dot, dash, space (SigValid 1 cycle each), OutReady=1 -> one word: EncSeq=10'b0001111111, SymCount=2, Space_EndSeqbar=1, Overflow=0, SentFlag 1->0.
- 6 dashes then end (MAX_SYMBOLS=5) -> EncSeq=10'b0101010101, SymCount=5, Overflow=1, Space_EndSeqbar=0.
- OutReady=0, push 4 words -> InReady=0 after the 4th. Further dots are not accepted (index unchanged). OutReady=1 for one cycle -> InReady=1; words emerge in order.
- Dot, dash, then Clear together with SigValid on a space -> no push, OutValid stays 0. Next dot, end -> EncSeq=10'b0011111111, SymCount=1.
- Space with empty buffer -> EncSeq=10'b1111111111, SymCount=0, Space_EndSeqbar=1.
- Assert Reset asynchronously mid-word with 2 words queued -> OutValid=0, InReady=1, SentFlag=1 immediately. Next word starts at slot 0.
